// File: rtl/series_ctrl.sv
// Moore sequencer for the alternating power-series datapath: load x/y, then per term
// tmp*=x^2, tmp*=coef, test tmp<y, res+=/-=tmp, bounded to MAX_TERMS accumulations.
module series_ctrl #(
  parameter int MAX_TERMS = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             parity,
  input  logic             stop_sign,
  output logic             reg_x_ld,
  output logic             reg_y_ld,
  output logic             reg_tmp_init1,
  output logic             reg_res_init1,
  output logic             cnt_init0,
  output logic             sel_x,
  output logic             sel_rom,
  output logic             reg_tmp_ld,
  output logic             cnt_en,
  output logic             reg_res_ld,
  output logic             invert,
  output logic             minus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_MUL_X   = 3'd2,
    S_MUL_ROM = 3'd3,
    S_CHECK   = 3'd4,
    S_ACCUM   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;

  logic load_q, load_d;
  logic sel_x_q, sel_x_d;
  logic sel_rom_q, sel_rom_d;
  logic tmp_ld_q, tmp_ld_d;
  logic cnt_en_q, cnt_en_d;
  logic res_ld_q, res_ld_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state and term counter
  always_comb begin
    state_d    = state_q;
    term_cnt_d = term_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          term_cnt_d = '0;
        end
      end
      S_LOAD:    state_d = S_MUL_X;
      S_MUL_X:   state_d = S_MUL_ROM;
      S_MUL_ROM: state_d = S_CHECK;
      S_CHECK:   state_d = stop_sign ? S_DONE : S_ACCUM;
      S_ACCUM: begin
        if (term_cnt_q != MAX_CNT) begin
          term_cnt_d = term_cnt_q + ONE;
        end
        state_d = (term_cnt_q >= MAX_CNT - ONE) ? S_DONE : S_MUL_X;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are flops aligned with state_q.
  always_comb begin
    load_d    = (state_d == S_LOAD);
    sel_x_d   = (state_d == S_MUL_X);
    sel_rom_d = (state_d == S_MUL_ROM);
    tmp_ld_d  = (state_d == S_MUL_X) || (state_d == S_MUL_ROM);
    cnt_en_d  = (state_d == S_MUL_ROM);
    res_ld_d  = (state_d == S_ACCUM);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      term_cnt_q <= '0;
      load_q     <= 1'b0;
      sel_x_q    <= 1'b0;
      sel_rom_q  <= 1'b0;
      tmp_ld_q   <= 1'b0;
      cnt_en_q   <= 1'b0;
      res_ld_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      term_cnt_q <= term_cnt_d;
      load_q     <= load_d;
      sel_x_q    <= sel_x_d;
      sel_rom_q  <= sel_rom_d;
      tmp_ld_q   <= tmp_ld_d;
      cnt_en_q   <= cnt_en_d;
      res_ld_q   <= res_ld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign reg_x_ld      = load_q;
  assign reg_y_ld      = load_q;
  assign reg_tmp_init1 = load_q;
  assign reg_res_init1 = load_q;
  assign cnt_init0     = load_q;
  assign sel_x         = sel_x_q;
  assign sel_rom       = sel_rom_q;
  assign reg_tmp_ld    = tmp_ld_q;
  assign cnt_en        = cnt_en_q;
  assign reg_res_ld    = res_ld_q;
  // parity reflects the coefficient counter already advanced in MUL_ROM, so it is live here
  assign invert        = res_ld_q & parity;
  assign minus         = res_ld_q & parity;
  assign busy          = busy_q;
  assign done          = done_q;
  assign term_cnt      = term_cnt_q;

endmodule

// File: tb/tb_series_ctrl.sv
// Bench for series_ctrl with a small Q2.8 datapath (x^2 multiplier, coefficient ROM, tmp/res).
module tb_series_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       parity;
  logic       stop_sign;
  logic       reg_x_ld, reg_y_ld, reg_tmp_init1, reg_res_init1, cnt_init0;
  logic       sel_x, sel_rom, reg_tmp_ld, cnt_en, reg_res_ld;
  logic       invert, minus, busy, done;
  logic [2:0] term_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  logic mon_en = 1'b0;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  series_ctrl #(.MAX_TERMS(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .parity(parity), .stop_sign(stop_sign),
    .reg_x_ld(reg_x_ld), .reg_y_ld(reg_y_ld), .reg_tmp_init1(reg_tmp_init1),
    .reg_res_init1(reg_res_init1), .cnt_init0(cnt_init0), .sel_x(sel_x), .sel_rom(sel_rom),
    .reg_tmp_ld(reg_tmp_ld), .cnt_en(cnt_en), .reg_res_ld(reg_res_ld), .invert(invert),
    .minus(minus), .busy(busy), .done(done), .term_cnt(term_cnt)
  );

  // Datapath: cosine-like series coefficients 1/2, 1/12, 1/30, 1/56 in Q2.8
  logic [9:0]  x_in = '0, y_in = '0;
  logic [9:0]  x_r = '0, y_r = '0, tmp_r = '0, res_r = '0;
  logic [1:0]  cnt_r = '0;
  logic [9:0]  rom [4] = '{10'h080, 10'h015, 10'h008, 10'h005};
  logic [19:0] xx, prod;
  logic [9:0]  operand, mul_out;

  always_comb begin
    xx        = x_r * x_r;
    operand   = sel_x ? xx[17:8] : rom[cnt_r];
    prod      = tmp_r * operand;
    mul_out   = prod[17:8];
    stop_sign = (tmp_r < y_r);
    parity    = cnt_r[0];
  end

  always @(posedge clk) begin
    if (reg_x_ld) x_r <= x_in;
    if (reg_y_ld) y_r <= y_in;
    if (reg_tmp_init1) tmp_r <= 10'h100;
    else if (reg_tmp_ld) tmp_r <= mul_out;
    if (reg_res_init1) res_r <= 10'h100;
    else if (reg_res_ld) res_r <= res_r + (invert ? ~tmp_r : tmp_r) + {9'b0, minus};
    if (cnt_init0) cnt_r <= '0;
    else if (cnt_en) cnt_r <= cnt_r + 2'd1;
    if (reg_x_ld) n_loads <= n_loads + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Per-cycle invariants
  always @(negedge clk) begin
    if (mon_en) begin
      check("sel_excl", {31'b0, sel_x & sel_rom}, 32'd0);
      check("inv_eq_minus", {31'b0, invert}, {31'b0, minus});
      check("inv_gate", {31'b0, invert & ~reg_res_ld}, 32'd0);
      check("res_ld_excl",
            {31'b0, reg_res_ld & (sel_x | sel_rom | reg_tmp_ld | cnt_en | done | reg_x_ld)}, 32'd0);
      if (done_prev) check("done_width", {31'b0, done}, 32'd0);
      done_prev <= done;
    end
  end

  function automatic logic [13:0] all_outs();
    return {reg_x_ld, reg_y_ld, reg_tmp_init1, reg_res_init1, cnt_init0, sel_x, sel_rom,
            reg_tmp_ld, cnt_en, reg_res_ld, invert, minus, busy, done};
  endfunction

  task automatic wait_done(input string tag, input int exp_cyc, output int cyc);
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_cycle"}, cyc, exp_cyc);
  endtask

  task automatic run(input string tag, input logic [9:0] x, input logic [9:0] y,
                     input int exp_cyc, input int exp_cnt, input logic [9:0] exp_res);
    int cyc;
    x_in = x;
    y_in = y;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_load"}, {27'b0, reg_x_ld, reg_y_ld, reg_tmp_init1, reg_res_init1, cnt_init0},
          32'h1f);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(tag, exp_cyc, cyc);
    check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
    check({tag, "_term_cnt"}, {29'b0, term_cnt}, exp_cnt);
    check({tag, "_result"}, {22'b0, res_r}, {22'b0, exp_res});
    $display("run %s: x=%h y=%h done cycle %0d term_cnt %0d result %h",
             tag, x, y, cyc, term_cnt, res_r);
    repeat (2) @(negedge clk);
    check({tag, "_idle"}, {18'b0, all_outs()}, 32'd0);
    check({tag, "_cnt_hold"}, {29'b0, term_cnt}, exp_cnt);
    check({tag, "_res_hold"}, {22'b0, res_r}, {22'b0, exp_res});
  endtask

  initial begin
    int cyc;
    logic saw_done;
    repeat (3) @(negedge clk);
    check("reset_outs", {18'b0, all_outs()}, 32'd0);
    check("reset_term_cnt", {29'b0, term_cnt}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run("stop3", 10'h100, 10'h001, 13, 2, 10'h08A);
    run("x_zero", 10'h000, 10'h001, 5, 0, 10'h100);
    run("cap", 10'h100, 10'h000, 18, 4, 10'h08A);

    // start held high across two runs
    n_loads = 0;
    x_in = 10'h100;
    y_in = 10'h001;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    wait_done("held1", 13, cyc);
    @(negedge clk);
    check("held_idle_busy", {31'b0, busy}, 32'd0);
    check("held_idle_load", {31'b0, reg_x_ld}, 32'd0);
    @(negedge clk);
    check("held_second_load", {31'b0, reg_x_ld}, 32'd1);
    start = 1'b0;
    wait_done("held2", 13, cyc);
    check("held2_result", {22'b0, res_r}, 32'h08A);
    @(negedge clk);
    check("held_load_count", n_loads, 32'd2);
    $display("run held: two runs, %0d loads, result %h", n_loads, res_r);

    // reset in MUL_ROM
    x_in = 10'h100;
    y_in = 10'h001;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_mul_rom", {30'b0, sel_rom, cnt_en}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_idle_outs", {18'b0, all_outs()}, 32'd0);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done = saw_done | done | busy;
    end
    check("rst_no_done", {31'b0, saw_done}, 32'd0);
    $display("run rst_mid: reset in MUL_ROM, busy %0d", busy);
    run("after_rst", 10'h100, 10'h001, 13, 2, 10'h08A);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
